// File: rtl/ahb_lite_master_pkg.sv
// ============================================================================
// Package     : ahb_lite_master_pkg
// Description : Shared AHB-Lite encodings and master FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_lite_master_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_DATA_LAST = 3'd2,
    ST_ERR1      = 3'd3,
    ST_ERR2      = 3'd4
  } mst_state_t;

  // Sizes above a word are not supported on this bus; fold them onto a word.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    logic [2:0] res;
    case (size)
      HSIZE_BYTE: res = HSIZE_BYTE;
      HSIZE_HALF: res = HSIZE_HALF;
      default:    res = HSIZE_WORD;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_addr_gen.sv
// ============================================================================
// Module      : ahb_addr_gen
// Description : Registered AHB address incrementer with 1 KB boundary flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_addr_gen #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [2:0]        size,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              boundary
);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_incr;

  assign w_incr = ADDR_W'(1) << size;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
    end else if (load) begin
      r_addr <= load_addr;
    end else if (step) begin
      r_addr <= r_addr + w_incr;
    end
  end

  assign addr     = r_addr;
  assign boundary = (r_addr[9:0] == 10'd0);

endmodule

`default_nettype wire

// File: rtl/ahb_lite_master.sv
// ============================================================================
// Module      : ahb_lite_master
// Description : Single-master AHB-Lite engine turning read/write commands into
//               INCR bursts. Optional HREADY timeout via AHB_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_lite_master
  import ahb_lite_master_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  mst_state_t        r_state;
  mst_state_t        w_next_state;
  htrans_t           w_htrans;

  logic              r_write;
  logic [2:0]        r_size;
  logic [2:0]        r_burst;
  logic [LEN_W-1:0]  r_beats_left;
  logic              r_first;
  logic              r_dphase;
  logic [DATA_W-1:0] r_hwdata;
  logic              r_done;
  logic              r_err;

  logic              w_accept_cmd;
  logic              w_beat_on;
  logic              w_accept_beat;
  logic              w_last_beat;
  logic              w_bus_active;
  logic              w_err_start;
  logic              w_err_end;
  logic              w_timeout;
  logic              w_force_idle;
  logic              w_boundary;

  assign w_bus_active  = (r_state == ST_ADDR) || (r_state == ST_DATA_LAST);
  assign w_accept_cmd  = cmd_valid && cmd_ready;
  assign w_err_start   = w_bus_active && HRESP && !HREADY;
  assign w_err_end     = (r_state == ST_ERR1) && HREADY && HRESP;
  assign w_force_idle  = w_err_start || w_timeout;
  assign w_last_beat   = (r_beats_left == LEN_W'(1));

  // A beat is offered only when write data is present; wr_valid is expected
  // to stay high until wr_ready, so an offered beat is never withdrawn.
  assign w_beat_on     = (r_state == ST_ADDR) && (!r_write || wr_valid) && !w_force_idle;
  assign w_accept_beat = w_beat_on && HREADY;

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);

  logic [c_cnt_w-1:0] r_to_cnt;
  logic               w_wait;

  assign w_wait    = w_bus_active && !HREADY && !HRESP;
  assign w_timeout = w_wait && (r_to_cnt == c_cnt_w'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (w_wait && !w_timeout) begin
      r_to_cnt <= r_to_cnt + c_cnt_w'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  ahb_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (w_accept_cmd),
    .load_addr (cmd_addr),
    .size      (r_size),
    .step      (w_accept_beat),
    .addr      (HADDR),
    .boundary  (w_boundary)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_cmd) w_next_state = ST_ADDR;
      end
      ST_ADDR: begin
        if (w_err_start)                      w_next_state = ST_ERR1;
        else if (w_timeout)                   w_next_state = ST_IDLE;
        else if (w_accept_beat && w_last_beat) w_next_state = ST_DATA_LAST;
      end
      ST_DATA_LAST: begin
        if (w_err_start)           w_next_state = ST_ERR1;
        else if (w_timeout)        w_next_state = ST_IDLE;
        else if (HREADY && !HRESP) w_next_state = ST_IDLE;
      end
      ST_ERR1: begin
        if (w_err_end) w_next_state = ST_ERR2;
      end
      ST_ERR2: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // First beat and any 1 KB restart must be NONSEQ; idle slots become BUSY
  // once the burst has started.
  always_comb begin
    w_htrans = HTRANS_IDLE;
    if ((r_state == ST_ADDR) && !w_force_idle) begin
      if (w_beat_on) begin
        w_htrans = (r_first || w_boundary) ? HTRANS_NONSEQ : HTRANS_SEQ;
      end else if (!r_first) begin
        w_htrans = HTRANS_BUSY;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write      <= 1'b0;
      r_size       <= 3'd0;
      r_burst      <= HBURST_SINGLE;
      r_beats_left <= '0;
      r_first      <= 1'b0;
    end else if (w_accept_cmd) begin
      r_write      <= cmd_write;
      r_size       <= clamp_size(cmd_size);
      r_burst      <= (cmd_len <= LEN_W'(1)) ? HBURST_SINGLE : HBURST_INCR;
      r_beats_left <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
      r_first      <= 1'b1;
    end else if (w_accept_beat) begin
      r_beats_left <= r_beats_left - LEN_W'(1);
      r_first      <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dphase <= 1'b0;
      r_hwdata <= '0;
    end else begin
      if (w_force_idle) begin
        r_dphase <= 1'b0;
      end else if (HREADY) begin
        r_dphase <= w_accept_beat;
      end
      if (w_accept_beat && r_write) begin
        r_hwdata <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= ((r_state == ST_DATA_LAST) && HREADY && !HRESP) || w_err_end || w_timeout;
      r_err  <= w_err_end || w_timeout;
    end
  end

  assign cmd_ready = (r_state == ST_IDLE) && !reset;
  assign wr_ready  = w_accept_beat && r_write;
  assign rd_valid  = w_bus_active && r_dphase && !r_write && HREADY && !HRESP;
  assign rd_data   = HRDATA;
  assign done      = r_done;
  assign err       = r_err;
  assign HTRANS    = w_htrans;
  assign HWRITE    = r_write;
  assign HSIZE     = r_size;
  assign HBURST    = r_burst;
  assign HWDATA    = r_hwdata;

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
// ============================================================================
// Module      : tb_ahb_lite_master
// Description : Directed self-checking bench for ahb_lite_master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_lite_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [4:0]  cmd_len;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int n_vec = 0;
  int n_err = 0;

  ahb_lite_master dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .done      (done),
    .err       (err),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmd(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [4:0] len);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_size  = sz;
    cmd_len   = len;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_len = '0; wr_valid = 1'b0; wr_data = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;

    // Reset state
    @(negedge clk); #1;
    check("rst_htrans", HTRANS, 0);
    check("rst_haddr", HADDR, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_done", done, 0);
    check("rst_hwdata", HWDATA, 0);
    @(negedge clk); reset = 1'b0; #1;
    check("idle_cmd_ready", cmd_ready, 1);

    // Single write
    @(negedge clk); cmd(1'b1, 32'h10, 3'd2, 5'd1); #1;
    check("t1_cmd_ready", cmd_ready, 1);
    @(negedge clk); cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 32'hDEADBEEF; #1;
    check("t1_htrans", HTRANS, 2);
    check("t1_haddr", HADDR, 32'h10);
    check("t1_hburst", HBURST, 0);
    check("t1_hwrite", HWRITE, 1);
    check("t1_hsize", HSIZE, 2);
    check("t1_wr_ready", wr_ready, 1);
    @(negedge clk); wr_valid = 1'b0; #1;
    check("t1_htrans_dl", HTRANS, 0);
    check("t1_hwdata", HWDATA, 32'hDEADBEEF);
    check("t1_done_early", done, 0);
    @(negedge clk); #1;
    check("t1_done", done, 1);
    check("t1_err", err, 0);
    check("t1_cmd_ready_after", cmd_ready, 1);
    @(negedge clk); #1;
    check("t1_done_pulse", done, 0);

    // Burst read with two wait states on beat 2
    @(negedge clk); cmd(1'b0, 32'h20, 3'd2, 5'd4); #1;
    @(negedge clk); cmd_valid = 1'b0; #1;
    check("t2_b1_htrans", HTRANS, 2);
    check("t2_b1_haddr", HADDR, 32'h20);
    check("t2_hburst", HBURST, 1);
    check("t2_b1_rd_valid", rd_valid, 0);
    @(negedge clk); HRDATA = 32'hA1; #1;
    check("t2_b2_htrans", HTRANS, 3);
    check("t2_b2_haddr", HADDR, 32'h24);
    check("t2_d1_rd_valid", rd_valid, 1);
    check("t2_d1_rd_data", rd_data, 32'hA1);
    @(negedge clk); HREADY = 1'b0; HRDATA = 32'hBAD; #1;
    check("t2_w1_haddr", HADDR, 32'h28);
    check("t2_w1_htrans", HTRANS, 3);
    check("t2_w1_rd_valid", rd_valid, 0);
    @(negedge clk); #1;
    check("t2_w2_haddr", HADDR, 32'h28);
    check("t2_w2_rd_valid", rd_valid, 0);
    @(negedge clk); HREADY = 1'b1; HRDATA = 32'hA2; #1;
    check("t2_b3_haddr", HADDR, 32'h28);
    check("t2_d2_rd_valid", rd_valid, 1);
    check("t2_d2_rd_data", rd_data, 32'hA2);
    @(negedge clk); HRDATA = 32'hA3; #1;
    check("t2_b4_haddr", HADDR, 32'h2C);
    check("t2_b4_htrans", HTRANS, 3);
    check("t2_d3_rd_data", rd_data, 32'hA3);
    @(negedge clk); HRDATA = 32'hA4; #1;
    check("t2_dl_htrans", HTRANS, 0);
    check("t2_d4_rd_valid", rd_valid, 1);
    check("t2_d4_rd_data", rd_data, 32'hA4);
    check("t2_done_early", done, 0);
    @(negedge clk); #1;
    check("t2_done", done, 1);
    check("t2_rd_valid_after", rd_valid, 0);

    // BUSY insertion on a 3-beat write
    @(negedge clk); cmd(1'b1, 32'h100, 3'd2, 5'd3); #1;
    @(negedge clk); cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 32'h11111111; #1;
    check("t3_b1_htrans", HTRANS, 2);
    check("t3_b1_wr_ready", wr_ready, 1);
    @(negedge clk); wr_valid = 1'b0; #1;
    check("t3_busy1_htrans", HTRANS, 1);
    check("t3_busy1_haddr", HADDR, 32'h104);
    check("t3_d1_hwdata", HWDATA, 32'h11111111);
    check("t3_busy1_wr_ready", wr_ready, 0);
    @(negedge clk); #1;
    check("t3_busy2_htrans", HTRANS, 1);
    @(negedge clk); wr_valid = 1'b1; wr_data = 32'h22222222; #1;
    check("t3_b2_htrans", HTRANS, 3);
    check("t3_b2_haddr", HADDR, 32'h104);
    @(negedge clk); wr_data = 32'h33333333; #1;
    check("t3_b3_htrans", HTRANS, 3);
    check("t3_b3_haddr", HADDR, 32'h108);
    check("t3_d2_hwdata", HWDATA, 32'h22222222);
    @(negedge clk); wr_valid = 1'b0; #1;
    check("t3_dl_htrans", HTRANS, 0);
    check("t3_d3_hwdata", HWDATA, 32'h33333333);
    @(negedge clk); #1;
    check("t3_done", done, 1);

    // 1 KB boundary restart
    @(negedge clk); cmd(1'b0, 32'h3F8, 3'd2, 5'd4); #1;
    @(negedge clk); cmd_valid = 1'b0; #1;
    check("t4_b1_haddr", HADDR, 32'h3F8);
    check("t4_b1_htrans", HTRANS, 2);
    @(negedge clk); #1;
    check("t4_b2_haddr", HADDR, 32'h3FC);
    check("t4_b2_htrans", HTRANS, 3);
    @(negedge clk); #1;
    check("t4_b3_haddr", HADDR, 32'h400);
    check("t4_b3_htrans", HTRANS, 2);
    @(negedge clk); #1;
    check("t4_b4_haddr", HADDR, 32'h404);
    check("t4_b4_htrans", HTRANS, 3);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("t4_done", done, 1);

    // ERROR response on beat 2 of a 4-beat read
    @(negedge clk); cmd(1'b0, 32'h40, 3'd2, 5'd4); #1;
    @(negedge clk); cmd_valid = 1'b0; #1;
    check("t5_b1_htrans", HTRANS, 2);
    @(negedge clk); HRDATA = 32'hE1; #1;
    check("t5_d1_rd_valid", rd_valid, 1);
    check("t5_b2_haddr", HADDR, 32'h44);
    @(negedge clk); HREADY = 1'b0; HRESP = 1'b1; #1;
    check("t5_e1_htrans", HTRANS, 0);
    check("t5_e1_rd_valid", rd_valid, 0);
    @(negedge clk); HREADY = 1'b1; #1;
    check("t5_e2_htrans", HTRANS, 0);
    check("t5_e2_rd_valid", rd_valid, 0);
    check("t5_e2_done", done, 0);
    @(negedge clk); HRESP = 1'b0; #1;
    check("t5_done", done, 1);
    check("t5_err", err, 1);
    check("t5_err2_cmd_ready", cmd_ready, 0);
    check("t5_err2_htrans", HTRANS, 0);
    @(negedge clk); #1;
    check("t5_cmd_ready", cmd_ready, 1);
    check("t5_err_pulse", err, 0);

    // Reset in the middle of an 8-beat burst, then a len=0 command
    @(negedge clk); cmd(1'b0, 32'h80, 3'd2, 5'd8); #1;
    @(negedge clk); cmd_valid = 1'b0; #1;
    check("t6_b1_htrans", HTRANS, 2);
    @(negedge clk); #1;
    check("t6_b2_haddr", HADDR, 32'h84);
    @(negedge clk); reset = 1'b1; #1;
    check("t6_rst_htrans", HTRANS, 0);
    check("t6_rst_haddr", HADDR, 0);
    check("t6_rst_hburst", HBURST, 0);
    check("t6_rst_hsize", HSIZE, 0);
    check("t6_rst_rd_valid", rd_valid, 0);
    check("t6_rst_cmd_ready", cmd_ready, 0);
    @(negedge clk); reset = 1'b0; #1;
    check("t6_rel_done", done, 0);
    check("t6_rel_cmd_ready", cmd_ready, 1);
    @(negedge clk); cmd(1'b0, 32'h200, 3'd1, 5'd0); #1;
    check("t6_no_done", done, 0);
    @(negedge clk); cmd_valid = 1'b0; #1;
    check("t6_n_htrans", HTRANS, 2);
    check("t6_n_haddr", HADDR, 32'h200);
    check("t6_n_hburst", HBURST, 0);
    check("t6_n_hsize", HSIZE, 1);
    @(negedge clk); HRDATA = 32'hCAFE; #1;
    check("t6_n_dl_htrans", HTRANS, 0);
    check("t6_n_rd_valid", rd_valid, 1);
    check("t6_n_rd_data", rd_data, 32'hCAFE);
    @(negedge clk); #1;
    check("t6_n_done", done, 1);
    check("t6_n_err", err, 0);

`ifdef AHB_MASTER_TIMEOUT_EN
    // HREADY stuck low for 64 cycles during the data phase
    @(negedge clk); cmd(1'b0, 32'h300, 3'd2, 5'd1); #1;
    @(negedge clk); cmd_valid = 1'b0; #1;
    check("t7_htrans", HTRANS, 2);
    @(negedge clk); HREADY = 1'b0; #1;
    for (int i = 1; i < 64; i++) begin
      @(negedge clk); #1;
    end
    check("t7_done_early", done, 0);
    @(negedge clk); #1;
    check("t7_done", done, 1);
    check("t7_err", err, 1);
    HREADY = 1'b1;
    @(negedge clk); #1;
    check("t7_cmd_ready", cmd_ready, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
